// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: result word width, source IDs
// and the result arbiter state encoding.
package alu_pkg;

    localparam int unsigned DATA_SIZE      = 16;
    localparam int unsigned ID_SIZE        = 8;
    // Result word = data, one status bit, then the tag ID.
    localparam int unsigned FIFO_OUT_WIDTH = DATA_SIZE + 1 + ID_SIZE;

    typedef enum logic {
        SRC_ADD = 1'b0,
        SRC_MUL = 1'b1
    } src_e;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_WRITE = 1'b1
    } arb_state_e;

    function automatic src_e other_src(input src_e s);
        return (s == SRC_ADD) ? SRC_MUL : SRC_ADD;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-requester round-robin grant; req_i[0] is the adder,
// req_i[1] the multiplier. Also usable on the FIFO_IN read side.
module rr_arb2
    import alu_pkg::*;
(
    input  logic [1:0] req_i,
    input  src_e       last_grant_i,
    output logic       gnt_valid_o,
    output src_e       gnt_o
);

    always_comb begin
        gnt_valid_o = |req_i;
        gnt_o       = SRC_ADD;
        case (req_i)
            2'b01:   gnt_o = SRC_ADD;
            2'b10:   gnt_o = SRC_MUL;
            // On a tie the source that did not win last time goes first.
            2'b11:   gnt_o = other_src(last_grant_i);
            default: gnt_o = SRC_ADD;
        endcase
    end

endmodule

// File: rtl/alu_result_arbiter.sv
// Shares the FIFO_OUT write port between the adder and multiplier result
// interfaces with round-robin fairness and saturating per-source counters.
module alu_result_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned FIFO_OUT_WIDTH = alu_pkg::FIFO_OUT_WIDTH,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      a_valid_res,
    input  logic [FIFO_OUT_WIDTH-1:0] result_add,
    input  logic                      m_valid_res,
    input  logic [FIFO_OUT_WIDTH-1:0] result_mul,
    input  logic                      ready_f_res,
    input  logic                      cnt_clr,
    output logic                      w_en_out,
    output logic [FIFO_OUT_WIDTH-1:0] fifo_res,
    output logic                      sum_written,
    output logic                      mul_written,
    output logic [CNT_WIDTH-1:0]      add_cnt,
    output logic [CNT_WIDTH-1:0]      mul_cnt
);

    arb_state_e                state_q,      state_d;
    src_e                      last_grant_q, last_grant_d;
    logic                      w_en_q,       w_en_d;
    logic [FIFO_OUT_WIDTH-1:0] fifo_res_q,   fifo_res_d;
    logic                      sum_wr_q,     sum_wr_d;
    logic                      mul_wr_q,     mul_wr_d;
    logic [CNT_WIDTH-1:0]      add_cnt_q,    add_cnt_d;
    logic [CNT_WIDTH-1:0]      mul_cnt_q,    mul_cnt_d;

    logic [1:0] req;
    logic       gnt_valid;
    src_e       gnt;

    // A source whose written pulse is still high is mid-handshake and must
    // not be granted again on the stale word.
    assign req = {m_valid_res & ~mul_wr_q, a_valid_res & ~sum_wr_q};

    rr_arb2 u_rr_arb2 (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .gnt_valid_o  (gnt_valid),
        .gnt_o        (gnt)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        w_en_d       = 1'b0;
        fifo_res_d   = fifo_res_q;
        sum_wr_d     = 1'b0;
        mul_wr_d     = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (ready_f_res && gnt_valid) begin
                    state_d      = ARB_WRITE;
                    last_grant_d = gnt;
                    w_en_d       = 1'b1;
                    fifo_res_d   = (gnt == SRC_ADD) ? result_add : result_mul;
                    sum_wr_d     = (gnt == SRC_ADD);
                    mul_wr_d     = (gnt == SRC_MUL);
                end
            end
            ARB_WRITE: begin
                // The write commits regardless of ready_f_res here: the grant
                // was taken while FIFO_OUT had room.
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        add_cnt_d = add_cnt_q;
        mul_cnt_d = mul_cnt_q;
        if (cnt_clr) begin
            add_cnt_d = '0;
            mul_cnt_d = '0;
        end else begin
            if (sum_wr_q && !(&add_cnt_q)) add_cnt_d = add_cnt_q + CNT_WIDTH'(1);
            if (mul_wr_q && !(&mul_cnt_q)) mul_cnt_d = mul_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= SRC_MUL;
            w_en_q       <= 1'b0;
            fifo_res_q   <= '0;
            sum_wr_q     <= 1'b0;
            mul_wr_q     <= 1'b0;
            add_cnt_q    <= '0;
            mul_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            w_en_q       <= w_en_d;
            fifo_res_q   <= fifo_res_d;
            sum_wr_q     <= sum_wr_d;
            mul_wr_q     <= mul_wr_d;
            add_cnt_q    <= add_cnt_d;
            mul_cnt_q    <= mul_cnt_d;
        end
    end

    assign w_en_out    = w_en_q;
    assign fifo_res    = fifo_res_q;
    assign sum_written = sum_wr_q;
    assign mul_written = mul_wr_q;
    assign add_cnt     = add_cnt_q;
    assign mul_cnt     = mul_cnt_q;

endmodule
